// File: rtl/uart_tx_arb.sv
// -----------------------------------------------------------------------------
// uart_tx_arb
//
// Shares the write port of the UART Tx FIFO between two byte producers
// (e.g. a CPU register path and a DMA engine). Grants are held for a whole
// packet so bytes from the two sources never interleave inside a packet. A
// burst limit caps the bytes accepted per grant so one source cannot starve
// the other. The policy is selectable at run time: round-robin or fixed
// priority with src0 highest.
//
// Ports
//   glb_clk, glb_rstn           clock, asynchronous active-low reset
//   Cfg_ctrl_Tx_en              0 stalls all acceptance (grant is kept)
//   Cfg_ctrl_prio               0 = round-robin, 1 = fixed priority (src0 high)
//   srcN_valid/data/last        byte stream of source N (N = 0, 1)
//   srcN_ready                  byte of source N accepted when valid is also 1
//   FIFO_ctrl_full              Tx FIFO full, blocks every transfer
//   fifo_w_en, fifo_w_data      Tx FIFO write strobe and data (0-cycle path)
//   arb_grant                   one-hot current grant, 00 = idle
//
// All outputs are combinational from the registered state and the current
// inputs, so a granted byte reaches the FIFO in the same cycle it is offered.
// -----------------------------------------------------------------------------
module uart_tx_arb #(
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned CNT_W     = 8
) (
    input  logic       glb_clk,
    input  logic       glb_rstn,
    input  logic       Cfg_ctrl_Tx_en,
    input  logic       Cfg_ctrl_prio,
    input  logic       src0_valid,
    input  logic [7:0] src0_data,
    input  logic       src0_last,
    output logic       src0_ready,
    input  logic       src1_valid,
    input  logic [7:0] src1_data,
    input  logic       src1_last,
    output logic       src1_ready,
    input  logic       FIFO_ctrl_full,
    output logic       fifo_w_en,
    output logic [7:0] fifo_w_data,
    output logic [1:0] arb_grant
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_G0   = 2'b01,
        ST_G1   = 2'b10
    } st_t;

    // Arbitration decision: returns {winner_valid, winner_index}.
    // In round-robin mode a tie goes to the source that was not granted last.
    function automatic logic [1:0] arb_pick(
        input logic v0,
        input logic v1,
        input logic prio,
        input logic lastg
    );
        logic [1:0] res;
        res = 2'b00;
        if (prio) begin
            if (v0) begin
                res = 2'b10;
            end else if (v1) begin
                res = 2'b11;
            end else begin
                res = 2'b00;
            end
        end else begin
            if (v0 && v1) begin
                res = {1'b1, ~lastg};
            end else if (v0) begin
                res = 2'b10;
            end else if (v1) begin
                res = 2'b11;
            end else begin
                res = 2'b00;
            end
        end
        return res;
    endfunction

    // Registered state
    st_t              st_r;
    logic [CNT_W-1:0] bcnt_r;
    logic             lastg_r;

    // Next-state values
    st_t              st_nxt_s;
    logic [CNT_W-1:0] bcnt_nxt_s;
    logic             lastg_nxt_s;

    // Decoded grant and muxed granted-source signals
    logic             is_g0_s;
    logic             is_g1_s;
    logic             cur_idx_s;
    logic             gnt_valid_s;
    logic             gnt_last_s;
    logic [7:0]       gnt_data_s;

    logic             can_accept_s;
    logic             xfer_s;
    logic [CNT_W-1:0] bcnt_inc_s;
    logic             burst_end_s;
    logic             release_s;
    logic             arb_lastg_s;
    logic [1:0]       pick_s;

    // Decode the grant and select the granted source's byte stream.
    // An unexpected state encoding decodes as idle so nothing is accepted.
    always_comb begin
        is_g0_s     = 1'b0;
        is_g1_s     = 1'b0;
        gnt_valid_s = 1'b0;
        gnt_last_s  = 1'b0;
        gnt_data_s  = 8'h00;
        case (st_r)
            ST_G0: begin
                is_g0_s     = 1'b1;
                gnt_valid_s = src0_valid;
                gnt_last_s  = src0_last;
                gnt_data_s  = src0_data;
            end
            ST_G1: begin
                is_g1_s     = 1'b1;
                gnt_valid_s = src1_valid;
                gnt_last_s  = src1_last;
                gnt_data_s  = src1_data;
            end
            default: begin
                is_g0_s     = 1'b0;
                is_g1_s     = 1'b0;
                gnt_valid_s = 1'b0;
                gnt_last_s  = 1'b0;
                gnt_data_s  = 8'h00;
            end
        endcase
    end

    // Handshake, transfer detection and release condition.
    always_comb begin
        cur_idx_s    = is_g1_s;
        can_accept_s = Cfg_ctrl_Tx_en & ~FIFO_ctrl_full;
        xfer_s       = (is_g0_s | is_g1_s) & gnt_valid_s & can_accept_s;
        bcnt_inc_s   = bcnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        burst_end_s  = (bcnt_inc_s == CNT_W'(MAX_BURST));
        release_s    = xfer_s & (gnt_last_s | burst_end_s);
        // On release the current owner counts as most recently granted, so a
        // round-robin tie is handed to the other source.
        if (is_g0_s | is_g1_s) begin
            arb_lastg_s = cur_idx_s;
        end else begin
            arb_lastg_s = lastg_r;
        end
        pick_s = arb_pick(src0_valid, src1_valid, Cfg_ctrl_prio, arb_lastg_s);
    end

    // Drive the outputs from the decoded grant and the current inputs.
    always_comb begin
        src0_ready  = is_g0_s & can_accept_s;
        src1_ready  = is_g1_s & can_accept_s;
        fifo_w_en   = xfer_s;
        fifo_w_data = gnt_data_s;
        arb_grant   = {is_g1_s, is_g0_s};
    end

    // Next-state logic: grant from idle, count bytes, release and re-arbitrate.
    always_comb begin
        st_nxt_s    = st_r;
        bcnt_nxt_s  = bcnt_r;
        lastg_nxt_s = lastg_r;
        case (st_r)
            ST_IDLE: begin
                // No byte is accepted in idle; the first transfer follows
                // the grant by one cycle.
                if (Cfg_ctrl_Tx_en && pick_s[1]) begin
                    st_nxt_s    = pick_s[0] ? ST_G1 : ST_G0;
                    bcnt_nxt_s  = {CNT_W{1'b0}};
                    lastg_nxt_s = pick_s[0];
                end else begin
                    st_nxt_s    = ST_IDLE;
                end
            end
            ST_G0, ST_G1: begin
                if (release_s) begin
                    // Hand off in the same cycle so back-to-back packets
                    // leave no gap on the FIFO write port.
                    bcnt_nxt_s = {CNT_W{1'b0}};
                    if (pick_s[1]) begin
                        st_nxt_s    = pick_s[0] ? ST_G1 : ST_G0;
                        lastg_nxt_s = pick_s[0];
                    end else begin
                        st_nxt_s    = ST_IDLE;
                        lastg_nxt_s = cur_idx_s;
                    end
                end else if (xfer_s) begin
                    bcnt_nxt_s = bcnt_inc_s;
                end else begin
                    // Stalled (no valid, FIFO full or Tx disabled): hold.
                    st_nxt_s   = st_r;
                    bcnt_nxt_s = bcnt_r;
                end
            end
            default: begin
                st_nxt_s    = ST_IDLE;
                bcnt_nxt_s  = {CNT_W{1'b0}};
                lastg_nxt_s = 1'b1;
            end
        endcase
    end

    // State registers; lastg resets to src1 so src0 wins the first tie.
    always_ff @(posedge glb_clk or negedge glb_rstn) begin
        if (!glb_rstn) begin
            st_r    <= ST_IDLE;
            bcnt_r  <= {CNT_W{1'b0}};
            lastg_r <= 1'b1;
        end else begin
            st_r    <= st_nxt_s;
            bcnt_r  <= bcnt_nxt_s;
            lastg_r <= lastg_nxt_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// -----------------------------------------------------------------------------
// Self-checking bench for uart_tx_arb (MAX_BURST = 4).
// Directed table of per-cycle vectors, a hand-written asynchronous reset
// sequence, then randomized traffic compared against a behavioural model.
// -----------------------------------------------------------------------------
module tb_uart_tx_arb;

    localparam int MB = 4;

    logic       glb_clk;
    logic       glb_rstn;
    logic       Cfg_ctrl_Tx_en;
    logic       Cfg_ctrl_prio;
    logic       src0_valid;
    logic [7:0] src0_data;
    logic       src0_last;
    logic       src0_ready;
    logic       src1_valid;
    logic [7:0] src1_data;
    logic       src1_last;
    logic       src1_ready;
    logic       FIFO_ctrl_full;
    logic       fifo_w_en;
    logic [7:0] fifo_w_data;
    logic [1:0] arb_grant;

    int n_cmp;
    int n_bad;

    uart_tx_arb #(.MAX_BURST(MB), .CNT_W(8)) dut (
        .glb_clk        (glb_clk),
        .glb_rstn       (glb_rstn),
        .Cfg_ctrl_Tx_en (Cfg_ctrl_Tx_en),
        .Cfg_ctrl_prio  (Cfg_ctrl_prio),
        .src0_valid     (src0_valid),
        .src0_data      (src0_data),
        .src0_last      (src0_last),
        .src0_ready     (src0_ready),
        .src1_valid     (src1_valid),
        .src1_data      (src1_data),
        .src1_last      (src1_last),
        .src1_ready     (src1_ready),
        .FIFO_ctrl_full (FIFO_ctrl_full),
        .fifo_w_en      (fifo_w_en),
        .fifo_w_data    (fifo_w_data),
        .arb_grant      (arb_grant)
    );

    initial glb_clk = 1'b0;
    always #5 glb_clk = ~glb_clk;

    typedef struct {
        logic       en;
        logic       prio;
        logic       v0;
        logic [7:0] d0;
        logic       l0;
        logic       v1;
        logic [7:0] d1;
        logic       l1;
        logic       full;
        logic       r0;
        logic       r1;
        logic       wen;
        logic [7:0] wd;
        logic [1:0] g;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(
        input logic en, input logic prio,
        input logic v0, input logic [7:0] d0, input logic l0,
        input logic v1, input logic [7:0] d1, input logic l1,
        input logic full,
        input logic r0, input logic r1, input logic wen,
        input logic [7:0] wd, input logic [1:0] g
    );
        vec_t v;
        v = '{en, prio, v0, d0, l0, v1, d1, l1, full, r0, r1, wen, wd, g};
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic r0, input logic r1,
                              input logic wen, input logic [7:0] wd, input logic [1:0] g);
        chk({tag, ".src0_ready"},  {7'd0, src0_ready}, {7'd0, r0});
        chk({tag, ".src1_ready"},  {7'd0, src1_ready}, {7'd0, r1});
        chk({tag, ".fifo_w_en"},   {7'd0, fifo_w_en},  {7'd0, wen});
        chk({tag, ".fifo_w_data"}, fifo_w_data,        wd);
        chk({tag, ".arb_grant"},   {6'd0, arb_grant},  {6'd0, g});
    endtask

    // ---------------- behavioural reference model ----------------
    int m_owner;   // -1 none, else source index holding the grant
    int m_count;   // bytes accepted in the current grant
    int m_lastw;   // most recently granted source

    function automatic int pick(input logic v0, input logic v1, input logic prio, input int lastw);
        if (prio) return v0 ? 0 : (v1 ? 1 : -1);
        if (v0 && v1) return (lastw == 0) ? 1 : 0;
        return v0 ? 0 : (v1 ? 1 : -1);
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_count = 0;
        m_lastw = 1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic       v[2];
        logic       l[2];
        logic [7:0] d[2];
        logic       e_r0, e_r1, e_wen;
        logic [7:0] e_wd;
        logic [1:0] e_g;
        int         w;

        n_cmp = 0;
        n_bad = 0;
        model_reset();

        // Reset state: outputs low even with requests pending.
        glb_rstn       = 1'b0;
        Cfg_ctrl_Tx_en = 1'b1;
        Cfg_ctrl_prio  = 1'b0;
        src0_valid = 1'b1; src0_data = 8'h5A; src0_last = 1'b0;
        src1_valid = 1'b1; src1_data = 8'hA5; src1_last = 1'b0;
        FIFO_ctrl_full = 1'b0;
        #2;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 8'h00, 2'b00);
        @(posedge glb_clk); #1;
        src0_valid = 1'b0; src1_valid = 1'b0;
        glb_rstn = 1'b1;

        //             en    prio  v0    d0     l0    v1    d1     l1    full   r0    r1    wen   wd     g
        vecs[0]  = mk(1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00);
        vecs[1]  = mk(1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 2'b01);
        vecs[2]  = mk(1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 2'b01);
        vecs[3]  = mk(1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 2'b01);
        vecs[4]  = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'b01);
        // FIFO full for three cycles mid-packet
        vecs[5]  = mk(1'b1, 1'b0, 1'b1, 8'h44, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 2'b01);
        vecs[6]  = mk(1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 2'b01);
        vecs[7]  = mk(1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 2'b01);
        vecs[8]  = mk(1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 2'b01);
        vecs[9]  = mk(1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 2'b01);
        vecs[10] = mk(1'b1, 1'b0, 1'b1, 8'h66, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h66, 2'b01);
        // Tx disabled: grant held, nothing accepted
        vecs[11] = mk(1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77, 2'b01);
        // Burst expiry after 4 bytes, src1 packet, then src0 remainder
        vecs[12] = mk(1'b1, 1'b0, 1'b1, 8'hA0, 1'b0, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA0, 2'b01);
        vecs[13] = mk(1'b1, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA1, 2'b01);
        vecs[14] = mk(1'b1, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA2, 2'b01);
        vecs[15] = mk(1'b1, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA3, 2'b01);
        vecs[16] = mk(1'b1, 1'b0, 1'b1, 8'hA4, 1'b0, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB0, 2'b10);
        vecs[17] = mk(1'b1, 1'b0, 1'b1, 8'hA4, 1'b0, 1'b1, 8'hB1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB1, 2'b10);
        vecs[18] = mk(1'b1, 1'b0, 1'b1, 8'hA4, 1'b0, 1'b1, 8'hC0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA4, 2'b01);
        vecs[19] = mk(1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 8'hC0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 2'b01);
        // Priority switch applies at the next decision; src0 then keeps winning
        vecs[20] = mk(1'b1, 1'b1, 1'b1, 8'hD0, 1'b1, 1'b1, 8'hC0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC0, 2'b10);
        vecs[21] = mk(1'b1, 1'b1, 1'b1, 8'hD0, 1'b1, 1'b1, 8'hE0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hD0, 2'b01);
        vecs[22] = mk(1'b1, 1'b1, 1'b1, 8'hD1, 1'b1, 1'b1, 8'hE0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hD1, 2'b01);
        vecs[23] = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hE0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'b01);

        for (int i = 0; i < 24; i++) begin
            Cfg_ctrl_Tx_en = vecs[i].en;
            Cfg_ctrl_prio  = vecs[i].prio;
            src0_valid = vecs[i].v0; src0_data = vecs[i].d0; src0_last = vecs[i].l0;
            src1_valid = vecs[i].v1; src1_data = vecs[i].d1; src1_last = vecs[i].l1;
            FIFO_ctrl_full = vecs[i].full;
            #3;
            check_outs($sformatf("vec%0d", i), vecs[i].r0, vecs[i].r1, vecs[i].wen, vecs[i].wd, vecs[i].g);
            @(posedge glb_clk); #1;
        end

        // Hand sequence: src1 mid-packet, asynchronous reset, then src0 first.
        Cfg_ctrl_prio = 1'b0;
        src0_valid = 1'b1; src0_data = 8'hF0; src0_last = 1'b1;
        src1_valid = 1'b1; src1_data = 8'h90; src1_last = 1'b0;
        #3 check_outs("hs_src0_last", 1'b1, 1'b0, 1'b1, 8'hF0, 2'b01);
        @(posedge glb_clk); #1;
        src0_valid = 1'b0; src0_last = 1'b0;
        src1_data = 8'h91;
        #3 check_outs("hs_src1_b0", 1'b0, 1'b1, 1'b1, 8'h91, 2'b10);
        @(posedge glb_clk); #1;
        src1_data = 8'h92;
        #1 check_outs("hs_src1_b1", 1'b0, 1'b1, 1'b1, 8'h92, 2'b10);
        glb_rstn = 1'b0;
        #1 check_outs("hs_async_rst", 1'b0, 1'b0, 1'b0, 8'h00, 2'b00);
        @(posedge glb_clk); #1;
        glb_rstn = 1'b1;
        src0_valid = 1'b1; src0_data = 8'hC1; src0_last = 1'b0;
        src1_valid = 1'b1; src1_data = 8'hC2; src1_last = 1'b0;
        #1 check_outs("hs_post_rst_idle", 1'b0, 1'b0, 1'b0, 8'h00, 2'b00);
        @(posedge glb_clk); #1;
        check_outs("hs_post_rst_src0", 1'b1, 1'b0, 1'b1, 8'hC1, 2'b01);

        // Randomized traffic against the reference model.
        glb_rstn = 1'b0;
        model_reset();
        @(posedge glb_clk); #1;
        glb_rstn = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            Cfg_ctrl_Tx_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) Cfg_ctrl_prio = ~Cfg_ctrl_prio;
            src0_valid = ($urandom_range(0, 3) != 0);
            src0_data  = 8'($urandom);
            src0_last  = ($urandom_range(0, 2) == 0);
            src1_valid = ($urandom_range(0, 3) != 0);
            src1_data  = 8'($urandom);
            src1_last  = ($urandom_range(0, 2) == 0);
            FIFO_ctrl_full = ($urandom_range(0, 4) == 0);

            v[0] = src0_valid; v[1] = src1_valid;
            l[0] = src0_last;  l[1] = src1_last;
            d[0] = src0_data;  d[1] = src1_data;

            e_r0  = (m_owner == 0) && Cfg_ctrl_Tx_en && !FIFO_ctrl_full;
            e_r1  = (m_owner == 1) && Cfg_ctrl_Tx_en && !FIFO_ctrl_full;
            e_wen = (e_r0 && v[0]) || (e_r1 && v[1]);
            e_wd  = (m_owner >= 0) ? d[m_owner] : 8'h00;
            e_g   = (m_owner == 0) ? 2'b01 : ((m_owner == 1) ? 2'b10 : 2'b00);
            #3;
            check_outs($sformatf("rnd%0d", c), e_r0, e_r1, e_wen, e_wd, e_g);

            if (m_owner < 0) begin
                if (Cfg_ctrl_Tx_en) begin
                    w = pick(v[0], v[1], Cfg_ctrl_prio, m_lastw);
                    if (w >= 0) begin
                        m_owner = w; m_count = 0; m_lastw = w;
                    end
                end
            end else if (e_wen) begin
                m_count++;
                if (l[m_owner] || m_count == MB) begin
                    m_lastw = m_owner;
                    w = pick(v[0], v[1], Cfg_ctrl_prio, m_lastw);
                    m_owner = w;
                    m_count = 0;
                    if (w >= 0) m_lastw = w;
                end
            end
            @(posedge glb_clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
